// File: rtl/mem_io_arbiter.sv
// Single-port data-memory arbiter for N requesters: round-robin or fixed
// priority, channel locking for bursts, and read returns tagged per channel.
module mem_io_arbiter #(
   parameter int unsigned N_CH   = 2,
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned RR_EN  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [N_CH-1:0]            req,
   input  logic [N_CH-1:0]            we,
   input  logic [N_CH-1:0]            lock,
   input  logic [N_CH*ADDR_W-1:0]     addr,
   input  logic [N_CH*DATA_W-1:0]     wdata,
   output logic [N_CH-1:0]            gnt,
   output logic [N_CH-1:0]            rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_wren,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [$clog2(N_CH)-1:0]    owner,
   output logic                       busy
);

   localparam int unsigned CH_W = $clog2(N_CH);

   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              lock_vld_q, lock_vld_d;
   logic [CH_W-1:0]   lock_own_q, lock_own_d;
   logic [CH_W-1:0]   owner_q, owner_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [CH_W-1:0]   tag_ch_q [RD_LAT];
   logic [CH_W-1:0]   tag_ch_d [RD_LAT];

   logic              win_vld;
   logic [CH_W-1:0]   win;

   // Winner: a still-requesting lock owner first, else a search from the pointer.
   always_comb begin
      int unsigned idx;
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      if (rst && enable) begin
         if (lock_vld_q && req[lock_own_q]) begin
            win_vld = 1'b1;
            win     = lock_own_q;
         end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
               idx = (RR_EN != 0) ? 32'(rr_ptr_q) + k : k;
               if (idx >= N_CH) idx = idx - N_CH;
               if (!win_vld && req[idx]) begin
                  win_vld = 1'b1;
                  win     = CH_W'(idx);
               end
            end
         end
      end
   end

   always_comb begin
      gnt       = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wren  = 1'b0;
      if (win_vld) begin
         gnt[win]  = 1'b1;
         mem_addr  = addr[32'(win) * ADDR_W +: ADDR_W];
         mem_wdata = wdata[32'(win) * DATA_W +: DATA_W];
         mem_wren  = we[win];
      end
   end

   always_comb begin
      rvalid = '0;
      if (tag_vld_q[RD_LAT-1]) rvalid[tag_ch_q[RD_LAT-1]] = 1'b1;
   end

   assign rdata = mem_rdata;
   assign busy  = |tag_vld_q;
   assign owner = owner_q;

   // No grant (enable low or nobody eligible) always drops the lock.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lock_vld_d = 1'b0;
      lock_own_d = lock_own_q;
      if (win_vld) begin
         rr_ptr_d   = (32'(win) + 1 == N_CH) ? '0 : win + 1'b1;
         owner_d    = win;
         lock_vld_d = lock[win];
         lock_own_d = win;
      end
      tag_vld_d[0] = win_vld && !we[win];
      tag_ch_d[0]  = win;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_ch_d[i]  = tag_ch_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_own_q <= '0;
         owner_q    <= '0;
         tag_vld_q  <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_ch_q[i] <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
         owner_q    <= owner_d;
         tag_vld_q  <= tag_vld_d;
         tag_ch_q   <= tag_ch_d;
      end
   end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: three configurations run in lockstep against a
// queue-based reference model, plus directed scenario checks.
module tb_mem_io_arbiter;

   localparam int NINST = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, en_s;
   logic [3:0]  req_s, we_s, lock_s;
   logic [31:0] addr_s, wdata_s;

   logic [3:0]  o_gnt    [NINST];
   logic [3:0]  o_rvalid [NINST];
   logic [7:0]  o_rdata  [NINST];
   logic [7:0]  o_maddr  [NINST];
   logic [7:0]  o_mwdata [NINST];
   logic        o_mwren  [NINST];
   logic        o_busy   [NINST];
   logic [1:0]  o_owner  [NINST];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, per instance.
   int         m_rr      [NINST];
   int         m_lock    [NINST];
   int         m_own     [NINST];
   bit         m_started [NINST];
   int         q_ch      [NINST][$];
   logic [7:0] q_d       [NINST][$];
   logic [7:0] ref_mem   [int];

   function automatic int cfg_n(int g);
      return (g == 0) ? 2 : (g == 1) ? 4 : 3;
   endfunction
   function automatic int cfg_rr(int g);
      return (g == 1) ? 0 : 1;
   endfunction
   function automatic int cfg_lat(int g);
      return g + 1;
   endfunction
   function automatic logic [7:0] init_val(int g, int a);
      return 8'(a * 7 + g * 31 + 3);
   endfunction

   for (genvar g = 0; g < NINST; g++) begin : g_inst
      localparam int N   = cfg_n(g);
      localparam int RR  = cfg_rr(g);
      localparam int LAT = cfg_lat(g);
      localparam int CW  = $clog2(N);

      logic [N-1:0]  gnt, rvalid;
      logic [7:0]    rdata, mem_addr, mem_wdata, mem_rdata;
      logic          mem_wren, busy;
      logic [CW-1:0] owner;
      bit            wr_flag [256];
      logic [7:0]    ram     [256];
      logic [7:0]    rpipe   [LAT];

      mem_io_arbiter #(
         .N_CH   (N),
         .ADDR_W (8),
         .DATA_W (8),
         .RD_LAT (LAT),
         .RR_EN  (RR)
      ) u_dut (
         .clk       (clk),
         .rst       (rst_s),
         .enable    (en_s),
         .req       (req_s[N-1:0]),
         .we        (we_s[N-1:0]),
         .lock      (lock_s[N-1:0]),
         .addr      (addr_s[N*8-1:0]),
         .wdata     (wdata_s[N*8-1:0]),
         .gnt       (gnt),
         .rvalid    (rvalid),
         .rdata     (rdata),
         .mem_addr  (mem_addr),
         .mem_wdata (mem_wdata),
         .mem_wren  (mem_wren),
         .mem_rdata (mem_rdata),
         .owner     (owner),
         .busy      (busy)
      );

      // RAM with a LAT-cycle read pipeline; unwritten words read as init_val.
      always @(posedge clk) begin
         if (mem_wren) begin
            ram[mem_addr]     <= mem_wdata;
            wr_flag[mem_addr] <= 1'b1;
         end
         rpipe[0] <= wr_flag[mem_addr] ? ram[mem_addr] : init_val(g, int'(mem_addr));
         for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
      end
      assign mem_rdata = rpipe[LAT-1];

      assign o_gnt[g]    = 4'(gnt);
      assign o_rvalid[g] = 4'(rvalid);
      assign o_rdata[g]  = rdata;
      assign o_maddr[g]  = mem_addr;
      assign o_mwdata[g] = mem_wdata;
      assign o_mwren[g]  = mem_wren;
      assign o_busy[g]   = busy;
      assign o_owner[g]  = 2'(owner);
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_rd(int g, int a);
      return ref_mem.exists(g * 256 + a) ? ref_mem[g * 256 + a] : init_val(g, a);
   endfunction

   function automatic int winner(int g);
      int n;
      int c;
      n = cfg_n(g);
      if (!rst_s || !en_s) return -1;
      if (m_lock[g] >= 0 && req_s[m_lock[g]]) return m_lock[g];
      for (int k = 0; k < n; k++) begin
         c = (cfg_rr(g) != 0) ? (m_rr[g] + k) % n : k;
         if (req_s[c]) return c;
      end
      return -1;
   endfunction

   task automatic check_models();
      for (int g = 0; g < NINST; g++) begin
         int         w;
         int         f;
         bit         bz;
         logic [7:0] ea;
         logic [7:0] ed;
         if (!m_started[g]) continue;
         w  = winner(g);
         ea = (w >= 0) ? addr_s[w*8 +: 8] : 8'h00;
         ed = (w >= 0) ? wdata_s[w*8 +: 8] : 8'h00;
         chk($sformatf("g%0d.gnt", g), 32'(o_gnt[g]), (w >= 0) ? 32'(1 << w) : 32'd0);
         chk($sformatf("g%0d.mem_wren", g), 32'(o_mwren[g]), (w >= 0) ? 32'(we_s[w]) : 32'd0);
         chk($sformatf("g%0d.mem_addr", g), 32'(o_maddr[g]), 32'(ea));
         chk($sformatf("g%0d.mem_wdata", g), 32'(o_mwdata[g]), 32'(ed));
         f = q_ch[g][0];
         chk($sformatf("g%0d.rvalid", g), 32'(o_rvalid[g]), (f >= 0) ? 32'(1 << f) : 32'd0);
         if (f >= 0) chk($sformatf("g%0d.rdata", g), 32'(o_rdata[g]), 32'(q_d[g][0]));
         bz = 1'b0;
         for (int i = 0; i < q_ch[g].size(); i++) if (q_ch[g][i] >= 0) bz = 1'b1;
         chk($sformatf("g%0d.busy", g), 32'(o_busy[g]), 32'(bz));
         chk($sformatf("g%0d.owner", g), 32'(o_owner[g]), 32'(m_own[g]));
      end
   endtask

   task automatic advance_models();
      for (int g = 0; g < NINST; g++) begin
         int w;
         int a;
         if (!rst_s) begin
            m_started[g] = 1'b1;
            m_rr[g]      = 0;
            m_lock[g]    = -1;
            m_own[g]     = 0;
            q_ch[g].delete();
            q_d[g].delete();
            for (int i = 0; i < cfg_lat(g); i++) begin
               q_ch[g].push_back(-1);
               q_d[g].push_back(8'h00);
            end
         end else if (m_started[g]) begin
            w = winner(g);
            void'(q_ch[g].pop_front());
            void'(q_d[g].pop_front());
            a = (w >= 0) ? int'(addr_s[w*8 +: 8]) : 0;
            if (w >= 0 && !we_s[w]) begin
               q_ch[g].push_back(w);
               q_d[g].push_back(ref_rd(g, a));
            end else begin
               q_ch[g].push_back(-1);
               q_d[g].push_back(8'h00);
            end
            if (w >= 0) begin
               m_rr[g]   = (w + 1) % cfg_n(g);
               m_own[g]  = w;
               m_lock[g] = lock_s[w] ? w : -1;
               if (we_s[w]) ref_mem[g * 256 + a] = wdata_s[w*8 +: 8];
            end else begin
               m_lock[g] = -1;
            end
         end
      end
   endtask

   task automatic mid();
      @(negedge clk);
      check_models();
   endtask

   task automatic fin();
      advance_models();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      mid();
      fin();
   endtask

   task automatic set_addr(int c, logic [7:0] a);
      addr_s[c*8 +: 8] = a;
   endtask

   initial begin
      rst_s = 1'b0; en_s = 1'b1; req_s = '0; we_s = '0; lock_s = '0;
      addr_s = '0; wdata_s = '0;
      @(posedge clk);
      #1;
      step();
      mid();
      for (int g = 0; g < NINST; g++) begin
         chk("rst.gnt", 32'(o_gnt[g]), 32'd0);
         chk("rst.rvalid", 32'(o_rvalid[g]), 32'd0);
         chk("rst.busy", 32'(o_busy[g]), 32'd0);
         chk("rst.owner", 32'(o_owner[g]), 32'd0);
      end
      fin();

      // Two-channel round robin, reads only.
      rst_s = 1'b1;
      set_addr(0, 8'h10); set_addr(1, 8'h11); set_addr(2, 8'h12); set_addr(3, 8'h13);
      for (int k = 0; k < 5; k++) begin
         req_s = (k < 4) ? 4'b0011 : 4'b0000;
         mid();
         if (k < 4) chk("rr.gnt", 32'(o_gnt[0]), 32'(1 << (k % 2)));
         if (k > 0) begin
            chk("rr.rvalid", 32'(o_rvalid[0]), 32'(1 << ((k - 1) % 2)));
            chk("rr.rdata", 32'(o_rdata[0]), 32'(init_val(0, 16 + (k - 1) % 2)));
         end
         fin();
      end

      // Fixed priority on the four-channel instance.
      req_s = 4'b1110;
      repeat (3) begin
         mid();
         chk("fixed.gnt", 32'(o_gnt[1]), 32'b0010);
         fin();
      end

      // Lock burst by channel 1 against a requesting channel 0.
      req_s = 4'b0010; lock_s = 4'b0010;
      step();
      req_s = 4'b0011;
      repeat (5) begin
         mid();
         chk("lock.gnt_rr", 32'(o_gnt[0]), 32'b0010);
         chk("lock.gnt_fixed", 32'(o_gnt[1]), 32'b0010);
         fin();
      end
      req_s = 4'b0001; lock_s = 4'b0000;
      mid();
      chk("unlock.gnt_rr", 32'(o_gnt[0]), 32'b0001);
      chk("unlock.gnt_fixed", 32'(o_gnt[1]), 32'b0001);
      fin();
      req_s = 4'b0011;
      mid();
      chk("unlock.cleared", 32'(o_gnt[1]), 32'b0001);
      fin();
      req_s = 4'b0000;
      repeat (3) step();

      // Latency 3: read, then write, then read back the written word.
      set_addr(0, 8'h10); set_addr(1, 8'h20); wdata_s[15:8] = 8'hA5;
      req_s = 4'b0001; we_s = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("lat3.rvalid", 32'(o_rvalid[2]), (k == 3) ? 32'b0001 : 32'd0);
         if (k == 1) chk("lat3.wren", 32'(o_mwren[2]), 32'd1);
         if (k == 3) chk("lat3.rdata", 32'(o_rdata[2]), 32'(init_val(2, 16)));
         fin();
         req_s = (k == 0) ? 4'b0010 : 4'b0000;
         we_s  = (k == 0) ? 4'b0010 : 4'b0000;
      end
      set_addr(0, 8'h20); req_s = 4'b0001; we_s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         mid();
         if (k == 3) begin
            chk("rdback.rvalid", 32'(o_rvalid[2]), 32'b0001);
            chk("rdback.rdata", 32'(o_rdata[2]), 32'hA5);
         end
         fin();
         req_s = 4'b0000;
      end

      // Enable dropped right after a read grant (latency 2 instance).
      set_addr(0, 8'h30); req_s = 4'b0001; we_s = 4'b0000;
      mid();
      chk("en.gnt_pre", 32'(o_gnt[1]), 32'b0001);
      fin();
      en_s = 1'b0; req_s = 4'b1111; we_s = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("en.gnt", 32'(o_gnt[1]), 32'd0);
         chk("en.wren", 32'(o_mwren[1]), 32'd0);
         chk("en.rvalid", 32'(o_rvalid[1]), (k == 1) ? 32'b0001 : 32'd0);
         chk("en.busy", 32'(o_busy[1]), (k < 2) ? 32'd1 : 32'd0);
         fin();
      end
      en_s = 1'b1; req_s = 4'b0000; we_s = 4'b0000;

      // Reset with reads in flight on the latency-3 instance.
      req_s = 4'b0011;
      step();
      step();
      rst_s = 1'b0;
      mid();
      chk("rstmid.gnt_low", 32'(o_gnt[2]), 32'd0);
      fin();
      mid();
      chk("rstmid.rvalid", 32'(o_rvalid[2]), 32'd0);
      chk("rstmid.busy", 32'(o_busy[2]), 32'd0);
      chk("rstmid.gnt", 32'(o_gnt[2]), 32'd0);
      chk("rstmid.owner", 32'(o_owner[2]), 32'd0);
      fin();
      rst_s = 1'b1; req_s = 4'b0000;
      repeat (4) begin
         mid();
         chk("rstmid.stale", 32'(o_rvalid[2]), 32'd0);
         fin();
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         rst_s = ($urandom_range(0, 49) != 0);
         en_s  = ($urandom_range(0, 7) != 0);
         req_s = 4'($urandom);
         we_s  = 4'($urandom);
         if ($urandom_range(0, 3) == 0) lock_s = 4'($urandom);
         for (int c = 0; c < 4; c++) set_addr(c, 8'($urandom_range(0, 15)));
         wdata_s = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_io_arbiter.md
Name: mem_io_arbiter

Overview:
Parametrised data-memory access arbiter. It generalises the fixed two-way CPU/VGA address and write-enable muxing and the read-data demux into N requesters with a per-cycle request/grant handshake. It supports round-robin or fixed priority, channel locking for streaming bursts, and read returns tagged to the requesting channel after a configurable memory latency. It sits between the processor, the VGA controller and other DMA-style masters on one side and the single-port data_memory RAM on the other.

Parameters:
N_CH, 2, number of requesting channels (2..8); channel 0 is highest fixed priority
ADDR_W, 19, memory address width
DATA_W, 8, memory data width
RD_LAT, 1, cycles from granted read to valid mem_rdata (1..4)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low
enable  in  1  global access enable; when low, no grants are issued
req  in  N_CH  per-channel access request
we  in  N_CH  per-channel write qualifier; 0 = read
lock  in  N_CH  per-channel hold-grant request
addr  in  N_CH*ADDR_W  packed channel addresses; channel i occupies [i*ADDR_W +: ADDR_W]
wdata  in  N_CH*DATA_W  packed channel write data
gnt  out  N_CH  one-hot grant for the current cycle
rvalid  out  N_CH  one-hot read-data-valid
rdata  out  DATA_W  read data, meaningful only where rvalid is set
mem_addr  out  ADDR_W  to RAM address
mem_wdata  out  DATA_W  to RAM data
mem_wren  out  1  to RAM write enable
mem_rdata  in  DATA_W  from RAM q
owner  out  $clog2(N_CH)  index of the current or last granted channel
busy  out  1  high while any read is in flight

Behaviour:
- Reset (rst low at a clock edge): RR pointer = 0, lock owner cleared, read-tag pipeline cleared. All of the following are 0 in the cycle after reset: gnt, rvalid, mem_wren, busy, owner.
- Grant is combinational in cycle t from req, enable and registered state. At most one gnt bit is set. gnt[i] requires req[i].
- Winner selection, in priority order:
  1. If the lock owner L is valid and req[L] is high, L wins.
  2. Otherwise, if RR_EN=1, the first requester searching upward from the RR pointer, with wrap at N_CH-1 -> 0.
  3. Otherwise (RR_EN=0), the lowest-index requester.
- Memory drive:
  - With a winner w: mem_addr = addr[w], mem_wdata = wdata[w], mem_wren = we[w].
  - With no winner: mem_wren = 0, mem_addr = 0, mem_wdata = 0.
- Edge after a grant to w:
  - RR pointer = (w+1) mod N_CH.
  - owner = w.
  - Lock owner = w if lock[w] was high; otherwise cleared.
- A locked channel whose req drops loses the lock on that edge. Arbitration resumes normally in the same cycle that req drops.
- Read return: a granted read (we[w]=0) pushes tag {valid, w} into an RD_LAT-deep shift pipeline. When the tag exits, rvalid[w] = 1 for one cycle and rdata = mem_rdata. Writes push an invalid tag.
- Throughput: one access per cycle; back-to-back reads from one channel return on consecutive cycles.
- busy = OR of all valid tags in the pipeline.
- enable low:
  - No grants and mem_wren = 0.
  - Lock owner cleared; RR pointer held.
  - In-flight reads still drain and assert rvalid.
- Simultaneous lock release by the owner and requests from others: the owner's req is low, so normal arbitration applies that cycle.
- Reset mid-operation: in-flight tags are discarded and no rvalid is produced for them.
- N_CH not a power of two: the pointer wraps at N_CH-1, never at 2^k-1.

Test Plan:
- Reset, then N_CH=2, RD_LAT=1, RR_EN=1, req=2'b11 both reads for 4 cycles -> gnt sequence 01,10,01,10. Each rvalid matches the grant one cycle later, with rdata equal to the RAM model contents at that channel's address.
- RR_EN=0, N_CH=4, req=4'b1110 held for 3 cycles -> gnt=0010 every cycle; channel 3 is never granted.
- Lock burst: ch1 holds req and lock for 5 cycles while ch0 req=1 -> gnt=10 for 5 cycles. Ch1 drops req -> gnt=01 in that same cycle, and the lock clears on the next edge.
- RD_LAT=3, ch0 reads addr 0x00010 and ch1 writes 0xA5 to 0x00020 in consecutive cycles -> rvalid=01 exactly 3 cycles after the read grant. No rvalid for the write. A later read of 0x00020 returns 0xA5.
- enable dropped the cycle after a read grant with RD_LAT=2 -> gnt=0 and mem_wren=0 while low. The pending rvalid still asserts once. Busy falls after the tag exits.
- rst pulled low with 2 reads in flight (RD_LAT=3) -> on the next cycle rvalid=0, busy=0, gnt=0 and owner=0. No stale rvalid appears afterwards.
